// File: rtl/mult32x32_pkg.sv
// Shared types and constants for the 32x32 multiplier front end.
package mult32x32_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESULT
    } front_state_t;

    localparam int unsigned MULT_STEPS      = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mult32x32_watchdog.sv
// Loadable watchdog counter; expired flags when the count equals LIMIT.
module mult32x32_watchdog #(
    parameter int unsigned CNT_W = 5,
    parameter int unsigned LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mult32x32_front.sv
// Valid/ready front end for the 32x32 multiplier with a hang watchdog.
// Optional signed operands: define MULT32X32_FRONT_SIGNED_EN.
module mult32x32_front
    import mult32x32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
`ifdef MULT32X32_FRONT_SIGNED_EN
    input  logic        in_signed,
`endif
    output logic        mult_start,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic        mult_busy,
    input  logic [63:0] mult_product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_product,
    output logic        out_err
);

    front_state_t state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         start_q, start_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  a_q, a_d, b_q, b_d;
    logic [63:0]  prod_q, prod_d;
    logic         err_q, err_d;
    logic [31:0]  op_a, op_b;
    logic [63:0]  cap_product;
    logic         wd_clr, wd_en, wd_expired;
    logic [CNT_W-1:0] wd_count;

`ifdef MULT32X32_FRONT_SIGNED_EN
    logic neg_q, neg_d, op_neg;

    // Multiplier is unsigned: feed magnitudes, restore the sign on capture.
    assign op_a        = (in_signed && in_a[31]) ? (~in_a + 32'd1) : in_a;
    assign op_b        = (in_signed && in_b[31]) ? (~in_b + 32'd1) : in_b;
    assign op_neg      = in_signed & (in_a[31] ^ in_b[31]);
    assign cap_product = neg_q ? (~mult_product + 64'd1) : mult_product;
`else
    assign op_a        = in_a;
    assign op_b        = in_b;
    assign cap_product = mult_product;
`endif

    mult32x32_watchdog #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (wd_clr),
        .en       (wd_en),
        .load     (1'b0),
        .load_val ('0),
        .count    (wd_count),
        .expired  (wd_expired)
    );

    assign wd_clr = (state_q == ST_LAUNCH);
    assign wd_en  = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        err_d   = err_q;
`ifdef MULT32X32_FRONT_SIGNED_EN
        neg_d   = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = op_a;
                    b_d     = op_b;
`ifdef MULT32X32_FRONT_SIGNED_EN
                    neg_d   = op_neg;
`endif
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                // Timeout wins over a busy edge in the same cycle.
                if (wd_expired) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESULT;
                end else if (mult_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (wd_expired) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESULT;
                end else if (!mult_busy) begin
                    prod_d  = cap_product;
                    err_d   = 1'b0;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered versions of the next state.
        in_ready_d  = (state_d == ST_IDLE);
        start_d     = (state_d == ST_LAUNCH);
        out_valid_d = (state_d == ST_RESULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            err_q       <= 1'b0;
`ifdef MULT32X32_FRONT_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            err_q       <= err_d;
`ifdef MULT32X32_FRONT_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign mult_start  = start_q;
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign out_valid   = out_valid_q;
    assign out_product = prod_q;
    assign out_err     = err_q;

endmodule

// File: tb/tb_mult32x32_front.sv
// Scoreboard bench for mult32x32_front with a behavioural 8-step multiplier.
module tb_mult32x32_front;

    localparam int unsigned TMO   = 16;
    localparam int unsigned STEPS = 8;
    localparam int NOM_LAT  = 11;
    localparam int HUNG_LAT = TMO + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_signed = 1'b0;
    logic        mult_start;
    logic [31:0] mult_a, mult_b;
    logic        mult_busy;
    logic [63:0] mult_product;
    logic        out_valid, out_ready;
    logic [63:0] out_product;
    logic        out_err;

    logic dir_ready = 1'b1, rnd_en = 1'b0, rnd_bit;
    assign out_ready = rnd_en ? rnd_bit : dir_ready;

    mult32x32_front #(.TIMEOUT_CYCLES(TMO), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
`ifdef MULT32X32_FRONT_SIGNED_EN
        .in_signed    (in_signed),
`endif
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    // Behavioural multiplier: busy for STEPS cycles after start, product valid when busy drops.
    int   mode = 0;   // 0 normal, 1 busy stuck high, 2 busy never rises
    logic mdl_kill = 1'b0;
    int   mcnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_busy    <= 1'b0;
            mult_product <= '0;
            mcnt         <= 0;
        end else if (mdl_kill) begin
            mult_busy <= 1'b0;
            mcnt      <= 0;
        end else if (mult_start && mode != 2) begin
            mult_busy <= 1'b1;
            mcnt      <= int'(STEPS) - 1;
        end else if (mult_busy && mode == 0) begin
            if (mcnt == 0) begin
                mult_busy    <= 1'b0;
                mult_product <= {32'd0, mult_a} * {32'd0, mult_b};
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    typedef struct {
        logic [63:0] prod;
        logic        err;
        int          lat;
        int          hs;
        logic [31:0] ma;
        logic [31:0] mb;
    } exp_t;

    exp_t exp_q[$];
    int   start_cycs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor_loop();
        logic prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid = 1'b0;
            end else begin
                if (mult_start) begin
                    start_cycs.push_back(cyc);
                    if (exp_q.size() == 0) chk("start_unexpected", 64'(mult_start), 64'd0);
                    else chk("start_cycle", 64'(cyc), 64'(exp_q[$].hs + 1));
                end
                if (mult_busy && exp_q.size() > 0) begin
                    chk("mult_a_hold", 64'(mult_a), 64'(exp_q[$].ma));
                    chk("mult_b_hold", 64'(mult_b), 64'(exp_q[$].mb));
                end
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) chk("valid_unexpected", 64'(out_valid), 64'd0);
                    else chk("latency", 64'(cyc - exp_q[0].hs), 64'(exp_q[0].lat));
                end
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("product", out_product, e.prod);
                    chk("err", 64'(out_err), 64'(e.err));
                end
                prev_valid = out_valid;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic hung, input logic keep);
        exp_t e;
        logic [63:0] sa, sb;
        int n = 0;
        sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        e.prod = hung ? 64'd0 : sa * sb;
        e.err  = hung;
        e.lat  = hung ? HUNG_LAT : NOM_LAT;
        e.ma   = (sgn && a[31]) ? -a : a;
        e.mb   = (sgn && b[31]) ? -b : b;
        in_a = a;
        in_b = b;
        in_signed = sgn;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
        end
        e.hs = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
        chk("mult_a_launch", 64'(mult_a), 64'(e.ma));
        chk("mult_b_launch", 64'(mult_b), 64'(e.mb));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                chk("drain_timeout", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0, n;
        logic sg;
        fork
            monitor_loop();
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_start", 64'(mult_start), 64'd0);
        chk("rst_mult_a", 64'(mult_a), 64'd0);
        chk("rst_mult_b", 64'(mult_b), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_product", out_product, 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single nominal operation
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0);
        drain();

        // Backpressure: result held for 20 cycles
        dir_ready = 1'b0;
        issue($urandom, $urandom, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        s0 = start_cycs.size();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) chk("bp_product_stable", out_product, exp_q[0].prod);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_no_restart", 64'(start_cycs.size()), 64'(s0));
        end
        @(posedge clk);
        #1;
        dir_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        drain();

        // Back-to-back with in_valid held high
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
        issue(32'd0, 32'd5, 1'b0, 1'b0, 1'b0);
        drain();
        chk("b2b_start_spacing",
            64'(start_cycs[start_cycs.size()-1] - start_cycs[start_cycs.size()-2]), 64'd12);

        // Hung multiplier: busy stuck high, then busy never rising
        mode = 1;
        issue($urandom, $urandom, 1'b0, 1'b1, 1'b0);
        drain();
        mode = 0;
        mdl_kill = 1'b1;
        @(posedge clk);
        #1;
        mdl_kill = 1'b0;
        mode = 2;
        issue($urandom, $urandom, 1'b0, 1'b1, 1'b0);
        drain();
        mode = 0;

        // Asynchronous reset during WAIT_DONE aborts the operation
        issue($urandom, $urandom, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_start", 64'(mult_start), 64'd0);
        chk("arst_mult_a", 64'(mult_a), 64'd0);
        chk("arst_mult_b", 64'(mult_b), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_product", out_product, 64'd0);
        chk("arst_out_err", 64'(out_err), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        issue(32'd3, 32'd7, 1'b0, 1'b0, 1'b0);
        drain();

`ifdef MULT32X32_FRONT_SIGNED_EN
        issue(32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, 1'b0);
        drain();
        issue(32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0);
        drain();
        issue(32'h80000000, 32'd1, 1'b1, 1'b0, 1'b0);
        drain();
`endif

        // Randomised operands, gaps and downstream backpressure
        rnd_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
`ifdef MULT32X32_FRONT_SIGNED_EN
            sg = 1'($urandom_range(0, 1));
`else
            sg = 1'b0;
`endif
            issue($urandom, $urandom, sg, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rnd_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
